// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32I core: phase encoding, opcodes,
// instruction classes and the immediate builder used by the decode stage.
package core_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WRITE  = 3'd4
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_LUI    = 4'd1,
    CLS_AUIPC  = 4'd2,
    CLS_JAL    = 4'd3,
    CLS_JALR   = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_LOAD   = 4'd6,
    CLS_STORE  = 4'd7,
    CLS_OP_IMM = 4'd8,
    CLS_OP     = 4'd9
  } op_class_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // All formats sign-extend from instr[31]; IMM_NONE yields zero.
  function automatic logic [31:0] build_imm(input imm_fmt_e fmt, input logic [31:0] ins);
    logic [31:0] res;
    res = '0;
    case (fmt)
      IMM_I:   res = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   res = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   res = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   res = {ins[31:12], 12'b0};
      IMM_J:   res = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports, one synchronous write
// port, x0 reads as zero, whole array cleared by asynchronous reset.
module reg_file
  import core_pkg::*;
#(
  parameter int XLEN_P  = XLEN,
  parameter int NREGS_P = NREGS,
  localparam int AW = $clog2(NREGS_P)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN_P-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [XLEN_P-1:0] rdata_a,
  output logic [XLEN_P-1:0] rdata_b
);

  logic [XLEN_P-1:0] regs_q [NREGS_P];
  logic [XLEN_P-1:0] regs_d [NREGS_P];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS_P; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Entry 0 is never written, but the read mux keeps x0 zero regardless.
  assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Decode stage of the multi-cycle RV32I core: latches the instruction fields,
// immediate, class and both operands in DECODE, and hosts the register file.
module decode_stage
  import core_pkg::*;
#(
  parameter int XLEN_P  = XLEN,
  parameter int NREGS_P = NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        state,
  input  logic [31:0]       instr,
  input  logic [31:0]       pc_in,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN_P-1:0] wb_data,
  output logic [31:0]       pc_out,
  output logic [XLEN_P-1:0] rs1_val,
  output logic [XLEN_P-1:0] rs2_val,
  output logic [XLEN_P-1:0] imm,
  output logic [4:0]        rd,
  output logic [2:0]        funct3,
  output logic              funct7_5,
  output logic [3:0]        op_class,
  output logic              illegal
);

  logic [XLEN_P-1:0] rdata_a;
  logic [XLEN_P-1:0] rdata_b;
  logic              rf_we;

  assign rf_we = (state == ST_WRITE) && wb_en;

  reg_file #(
    .XLEN_P (XLEN_P),
    .NREGS_P(NREGS_P)
  ) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr_a(instr[19:15]),
    .raddr_b(instr[24:20]),
    .rdata_a(rdata_a),
    .rdata_b(rdata_b)
  );

  logic [31:0]       pc_q, pc_d;
  logic [XLEN_P-1:0] rs1_val_q, rs1_val_d;
  logic [XLEN_P-1:0] rs2_val_q, rs2_val_d;
  logic [XLEN_P-1:0] imm_q, imm_d;
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              funct7_5_q, funct7_5_d;
  op_class_e         op_class_q, op_class_d;
  logic              illegal_q, illegal_d;

  op_class_e cls;
  imm_fmt_e  fmt;
  logic      bad_opc;

  always_comb begin
    cls     = CLS_NONE;
    fmt     = IMM_NONE;
    bad_opc = 1'b0;
    case (instr[6:0])
      OPC_LUI:    begin cls = CLS_LUI;    fmt = IMM_U; end
      OPC_AUIPC:  begin cls = CLS_AUIPC;  fmt = IMM_U; end
      OPC_JAL:    begin cls = CLS_JAL;    fmt = IMM_J; end
      OPC_JALR:   begin cls = CLS_JALR;   fmt = IMM_I; end
      OPC_BRANCH: begin cls = CLS_BRANCH; fmt = IMM_B; end
      OPC_LOAD:   begin cls = CLS_LOAD;   fmt = IMM_I; end
      OPC_STORE:  begin cls = CLS_STORE;  fmt = IMM_S; end
      OPC_OP_IMM: begin cls = CLS_OP_IMM; fmt = IMM_I; end
      OPC_OP:     begin cls = CLS_OP;     fmt = IMM_NONE; end
      default:    bad_opc = 1'b1;
    endcase
  end

  // Everything holds outside DECODE; branches, stores and illegal opcodes
  // report rd=0 so nothing downstream can write back.
  always_comb begin
    pc_d       = pc_q;
    rs1_val_d  = rs1_val_q;
    rs2_val_d  = rs2_val_q;
    imm_d      = imm_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    funct7_5_d = funct7_5_q;
    op_class_d = op_class_q;
    illegal_d  = illegal_q;
    if (state == ST_DECODE) begin
      pc_d       = pc_in;
      rs1_val_d  = rdata_a;
      rs2_val_d  = rdata_b;
      imm_d      = XLEN_P'($signed(build_imm(fmt, instr)));
      funct3_d   = instr[14:12];
      funct7_5_d = instr[30];
      op_class_d = cls;
      illegal_d  = bad_opc;
      if (bad_opc || (cls == CLS_BRANCH) || (cls == CLS_STORE)) begin
        rd_d = '0;
      end else begin
        rd_d = instr[11:7];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7_5_q <= 1'b0;
      op_class_q <= CLS_NONE;
      illegal_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rs1_val_q  <= rs1_val_d;
      rs2_val_q  <= rs2_val_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      funct7_5_q <= funct7_5_d;
      op_class_q <= op_class_d;
      illegal_q  <= illegal_d;
    end
  end

  assign pc_out   = pc_q;
  assign rs1_val  = rs1_val_q;
  assign rs2_val  = rs2_val_q;
  assign imm      = imm_q;
  assign rd       = rd_q;
  assign funct3   = funct3_q;
  assign funct7_5 = funct7_5_q;
  assign op_class = op_class_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a vector table of decodes with
// expected fields, queued on drive and compared once the stage has latched.
module tb_decode_stage;
  import core_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f75;
    logic [3:0]  cls;
    logic        ill;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [2:0]  state;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] pc_out;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [3:0]  op_class;
  logic        illegal;

  int checkCount;
  int passCount;
  int tagCount;
  vec_t sb[$];
  vec_t vecs[16];

  decode_stage dut (
    .clk     (clk),
    .rst     (rst),
    .state   (state),
    .instr   (instr),
    .pc_in   (pc_in),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .pc_out  (pc_out),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .imm     (imm),
    .rd      (rd),
    .funct3  (funct3),
    .funct7_5(funct7_5),
    .op_class(op_class),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string name, input int tag,
                            input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL c%0d.%s got %h expected %h", tag, name, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  // Pops the oldest expectation and compares every output against it.
  task automatic checkOutput();
    vec_t e;
    tagCount++;
    if (sb.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL c%0d.scoreboard got empty expected entry", tagCount);
      return;
    end
    e = sb.pop_front();
    checkField("pc_out",   tagCount, pc_out,            e.pc);
    checkField("rs1_val",  tagCount, rs1_val,           e.rs1v);
    checkField("rs2_val",  tagCount, rs2_val,           e.rs2v);
    checkField("imm",      tagCount, imm,               e.imm);
    checkField("rd",       tagCount, {27'b0, rd},       {27'b0, e.rd});
    checkField("funct3",   tagCount, {29'b0, funct3},   {29'b0, e.f3});
    checkField("funct7_5", tagCount, {31'b0, funct7_5}, {31'b0, e.f75});
    checkField("op_class", tagCount, {28'b0, op_class}, {28'b0, e.cls});
    checkField("illegal",  tagCount, {31'b0, illegal},  {31'b0, e.ill});
  endtask

  // Drives one DECODE cycle, queues its expectation, then moves to EXEC.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    state = ST_DECODE;
    instr = v.instr;
    pc_in = v.pc;
    wb_en = 1'b0;
    sb.push_back(v);
    @(negedge clk);
    state = ST_EXEC;
  endtask

  task automatic doWrite(input logic [2:0] st, input logic [4:0] r, input logic [31:0] d);
    @(negedge clk);
    state   = st;
    wb_en   = 1'b1;
    wb_rd   = r;
    wb_data = d;
    @(negedge clk);
    state = ST_FETCH;
    wb_en = 1'b0;
  endtask

  task automatic holdStep(input logic [2:0] st, input vec_t v);
    @(negedge clk);
    state = st;
    instr = 32'h0020D463;
    pc_in = 32'hDEAD0000;
    sb.push_back(v);
    @(negedge clk);
    checkOutput();
  endtask

  vec_t zeroRec;
  vec_t jalZero;
  vec_t bgeAfterReset;

  initial begin
    checkCount = 0;
    passCount  = 0;
    tagCount   = 0;
    rst     = 1'b1;
    state   = ST_FETCH;
    instr   = '0;
    pc_in   = '0;
    wb_en   = 1'b0;
    wb_rd   = '0;
    wb_data = '0;

    //            instr         pc            rs1v   rs2v   imm           rd     f3    f75   cls   ill
    vecs[0]  = '{32'h00400093, 32'h00001000, 32'd0, 32'd0, 32'h00000004, 5'd1,  3'd0, 1'b0, 4'd8, 1'b0};
    vecs[1]  = '{32'hFFF00193, 32'h00001004, 32'd0, 32'd0, 32'hFFFFFFFF, 5'd3,  3'd0, 1'b1, 4'd8, 1'b0};
    vecs[2]  = '{32'h0020D463, 32'h00001008, 32'd4, 32'd3, 32'h00000008, 5'd0,  3'd5, 1'b0, 4'd5, 1'b0};
    vecs[3]  = '{32'h0080006F, 32'h0000100C, 32'd0, 32'd0, 32'h00000008, 5'd0,  3'd0, 1'b0, 4'd3, 1'b0};
    vecs[4]  = '{32'h123452B7, 32'h00001010, 32'd0, 32'd0, 32'h12345000, 5'd5,  3'd5, 1'b0, 4'd1, 1'b0};
    vecs[5]  = '{32'hFFFFF517, 32'h00001014, 32'd0, 32'd0, 32'hFFFFF000, 5'd10, 3'd7, 1'b1, 4'd2, 1'b0};
    vecs[6]  = '{32'hFFC0A583, 32'h00001018, 32'd4, 32'd0, 32'hFFFFFFFC, 5'd11, 3'd2, 1'b1, 4'd6, 1'b0};
    vecs[7]  = '{32'h0020A623, 32'h0000101C, 32'd4, 32'd3, 32'h0000000C, 5'd0,  3'd2, 1'b0, 4'd7, 1'b0};
    vecs[8]  = '{32'hFE20AC23, 32'h00001020, 32'd4, 32'd3, 32'hFFFFFFF8, 5'd0,  3'd2, 1'b1, 4'd7, 1'b0};
    vecs[9]  = '{32'h010100E7, 32'h00001024, 32'd3, 32'd0, 32'h00000010, 5'd1,  3'd0, 1'b0, 4'd4, 1'b0};
    vecs[10] = '{32'hFE000EE3, 32'h00001028, 32'd0, 32'd0, 32'hFFFFFFFC, 5'd0,  3'd0, 1'b1, 4'd5, 1'b0};
    vecs[11] = '{32'hFF9FF0EF, 32'h0000102C, 32'd0, 32'd0, 32'hFFFFFFF8, 5'd1,  3'd7, 1'b1, 4'd3, 1'b0};
    vecs[12] = '{32'h00000000, 32'h00001030, 32'd0, 32'd0, 32'h00000000, 5'd0,  3'd0, 1'b0, 4'd0, 1'b1};
    vecs[13] = '{32'h002082FF, 32'h00001034, 32'd4, 32'd3, 32'h00000000, 5'd0,  3'd0, 1'b0, 4'd0, 1'b1};
    vecs[14] = '{32'h00000333, 32'h00001038, 32'd0, 32'd0, 32'h00000000, 5'd6,  3'd0, 1'b0, 4'd9, 1'b0};
    vecs[15] = '{32'h001283B3, 32'h0000103C, 32'd0, 32'd4, 32'h00000000, 5'd7,  3'd0, 1'b0, 4'd9, 1'b0};

    zeroRec       = '{32'h0, 32'h0, 32'd0, 32'd0, 32'h0, 5'd0, 3'd0, 1'b0, 4'd0, 1'b0};
    jalZero       = '{32'h0000006F, 32'h00001100, 32'd0, 32'd0, 32'h0, 5'd0, 3'd0, 1'b0, 4'd3, 1'b0};
    bgeAfterReset = '{32'h0020D463, 32'h00002000, 32'd0, 32'd0, 32'h8, 5'd0, 3'd5, 1'b0, 4'd5, 1'b0};

    repeat (2) @(negedge clk);
    sb.push_back(zeroRec);
    checkOutput();
    rst = 1'b0;

    for (int i = 0; i < 2; i++) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    doWrite(ST_WRITE, 5'd1, 32'd4);
    doWrite(ST_WRITE, 5'd2, 32'd3);

    for (int i = 2; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    doWrite(ST_WRITE, 5'd0, 32'hDEADBEEF);
    applyStimulus(vecs[14]);
    checkOutput();

    doWrite(ST_EXEC, 5'd5, 32'h55555555);
    for (int s = 5; s < 8; s++) begin
      doWrite(3'(s), 5'd5, 32'hAAAAAAAA);
    end
    applyStimulus(vecs[15]);
    checkOutput();

    applyStimulus(jalZero);
    checkOutput();
    for (int s = 2; s < 8; s++) begin
      holdStep(3'(s), jalZero);
    end

    // Asynchronous reset in the middle of a DECODE cycle.
    applyStimulus(vecs[6]);
    checkOutput();
    @(negedge clk);
    state = ST_DECODE;
    instr = 32'h0020D463;
    pc_in = 32'h00002000;
    #2 rst = 1'b1;
    #1;
    sb.push_back(zeroRec);
    checkOutput();
    #1 rst = 1'b0;
    sb.push_back(bgeAfterReset);
    @(negedge clk);
    state = ST_EXEC;
    checkOutput();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second stage of the multi-cycle RV32I core. Sits directly downstream of the fetch stage and consumes its 32-bit instruction word.
- In the DECODE state it latches the instruction and PC, splits out the fields, generates the sign-extended immediate, classifies the opcode and reads two operands from the integer register file.
- It owns the 32x32 register file. The write-back stage writes into it during the WRITE state.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- state  in  3  core phase: FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4.
- instr  in  32  instruction word from fetch; valid while state==1.
- pc_in  in  32  PC of that instruction.
- wb_en  in  1  register write request.
- wb_rd  in  5  write destination register.
- wb_data  in  XLEN  write data.
- pc_out  out  32  latched PC.
- rs1_val  out  XLEN  operand A.
- rs2_val  out  XLEN  operand B.
- imm  out  XLEN  sign-extended immediate.
- rd  out  5  destination register index.
- funct3  out  3  instr[14:12].
- funct7_5  out  1  instr[30].
- op_class  out  4  instruction class code (see package).
- illegal  out  1  unsupported opcode.

Behaviour:
- Reset (async, asserted):
  - All outputs go to 0.
  - op_class goes to CLS_NONE.
  - All register file entries are cleared to 0.
- Decode latch:
  - On a rising edge with state==1 (and not in reset), every output is registered from instr and pc_in. Outputs are valid from the next cycle, i.e. during EXEC. Latency is 1 cycle.
  - For any other state value, all decode outputs hold their previous values.
- Field extraction:
  - rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7].
  - rs1_val and rs2_val come from the register file contents at that same edge.
  - Index 0 always reads 0.
- Opcode classes, from instr[6:0]:
  - 0110111 LUI: U-type immediate.
  - 0010111 AUIPC: U-type immediate.
  - 1101111 JAL: J-type immediate.
  - 1100111 JALR: I-type immediate.
  - 1100011 BRANCH: B-type immediate.
  - 0000011 LOAD: I-type immediate.
  - 0100011 STORE: S-type immediate.
  - 0010011 OP_IMM: I-type immediate.
  - 0110011 OP: imm=0.
- Immediate formats (standard RV32I bit scatter), all sign-extended from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Illegal opcode (any other value, including all-zero):
  - Set illegal=1, op_class=CLS_NONE, rd=0, imm=0.
  - rs1_val/rs2_val are still latched.
  - illegal clears on the next legal decode.
- BRANCH and STORE force rd=0, so no write-back side effect is possible downstream.
- Register write:
  - On a rising edge with state==4 and wb_en==1 and wb_rd!=0, regs[wb_rd] <= wb_data.
  - Writes to x0 are ignored.
  - wb_en in any other state is ignored.
- Write-then-read: state values are mutually exclusive, so write and read never collide and no bypass is required. A value written in WRITE is visible at the next DECODE.
- Reset mid-decode: async clear wins immediately. The first legal decode after rst deasserts sees zeroed registers.
- Out-of-range state values (5-7) behave as non-DECODE, non-WRITE: nothing changes.

Decomposition:
- Package core_pkg:
  - State constants ST_FETCH..ST_WRITE, shared with fetch and later stages.
  - Opcode constants.
  - op_class encoding: CLS_NONE=0, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
- Sub-module reg_file:
  - Two combinational read ports and one synchronous write port.
  - x0 hardwired to zero; async reset clears all entries.
  - decode_stage instantiates it and registers its read data.

Test Plan:
- Reset then decode addi x1,x0,4 (0x00400093): the next cycle shows op_class=OP_IMM, rd=1, imm=0x00000004, rs1_val=0, illegal=0.
- Decode addi x3,x0,-1 (0xFFF00193) -> imm=0xFFFFFFFF, rd=3.
- WRITE with wb_rd=1, wb_data=4; WRITE with wb_rd=2, wb_data=3; then decode bge x1,x2 (0x0020D463) -> rs1_val=4, rs2_val=3, funct3=5, imm=8, op_class=BRANCH, rd=0.
- Decode jal x0,+8 (0x0080006F) -> imm=8, op_class=JAL. Then decode 0x0000006F -> imm=0, and outputs hold steady through states 2, 3, 4.
- WRITE with wb_rd=0, wb_data=0xDEADBEEF, then decode an instruction reading x0 -> rs1_val=0. Assert wb_en=1 in state 2 with wb_rd=5 -> x5 is unchanged.
- Decode 0x00000000 -> illegal=1, op_class=CLS_NONE. Assert rst mid-cycle in DECODE -> outputs and registers are 0 immediately, before the next clock edge.
